// File: rtl/credits_pkg.sv
// Shared types and widths for the credits title scroller slice.
package credits_pkg;

   // Scroller phases: hidden, moving up, parked at the final row.
   typedef enum logic [1:0] {IDLE, SCROLL, HOLD} scroll_state_t;

   // Screen coordinate width, plus one guard bit for wrap-free compares.
   localparam int COORD_W = 11;
   localparam int CMP_W   = COORD_W + 1;

   // Zero-extend a coordinate into the compare width.
   function automatic logic [CMP_W-1:0] widen(input logic [COORD_W-1:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/credits_title_scroller_if.sv
// Frame/pixel request side and window/status result side of the title scroller.
interface credits_title_scroller_if;
   import credits_pkg::*;

   logic               startOfFrame;
   logic               start;
   logic               abort;
   logic [COORD_W-1:0] pixelX;
   logic [COORD_W-1:0] pixelY;
   logic               InsideRectangle;
   logic [COORD_W-1:0] offsetX;
   logic [COORD_W-1:0] offsetY;
   logic [COORD_W-1:0] topLeftY;
   logic               busy;
   logic               done;

   // Video timing / game-state side that drives requests and consumes results.
   modport master (
      output startOfFrame, start, abort, pixelX, pixelY,
      input  InsideRectangle, offsetX, offsetY, topLeftY, busy, done
   );

   // The scroller itself.
   modport slave (
      input  startOfFrame, start, abort, pixelX, pixelY,
      output InsideRectangle, offsetX, offsetY, topLeftY, busy, done
   );

endinterface

// File: rtl/credits_title_scroller_window.sv
// Combinational window test and offset subtraction for the title rectangle.
module title_rect_window
   import credits_pkg::*;
#(
   parameter int OBJECT_WIDTH_X  = 64,
   parameter int OBJECT_HEIGHT_Y = 16,
   parameter int START_X         = 288
) (
   input  logic               enable,
   input  logic [COORD_W-1:0] pixel_x,
   input  logic [COORD_W-1:0] pixel_y,
   input  logic [COORD_W-1:0] top_left_y,
   output logic               in_window,
   output logic [COORD_W-1:0] offset_x,
   output logic [COORD_W-1:0] offset_y
);

   localparam logic [CMP_W-1:0]   X_LO    = CMP_W'(START_X);
   localparam logic [CMP_W-1:0]   X_HI    = CMP_W'(START_X + OBJECT_WIDTH_X);
   localparam logic [CMP_W-1:0]   H_EXT   = CMP_W'(OBJECT_HEIGHT_Y);
   localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);

   // The bottom edge gets the guard bit so a title near the screen bottom cannot wrap.
   logic [CMP_W-1:0] y_hi;
   assign y_hi = widen(top_left_y) + H_EXT;

   // Window membership, then offsets that are forced to zero outside the window.
   always_comb begin
      // NOTE: every output gets a default before any branch so no latch is inferred.
      offset_x  = '0;
      offset_y  = '0;
      in_window = enable
                  && (widen(pixel_x) >= X_LO) && (widen(pixel_x) < X_HI)
                  && (widen(pixel_y) >= widen(top_left_y)) && (widen(pixel_y) < y_hi);
      if (in_window) begin
         offset_x = pixel_x - X_START;
         offset_y = pixel_y - top_left_y;
      end
   end

endmodule

// File: rtl/credits_title_scroller.sv
// Credits title scroller: moves the title up one step per frame, parks it, then reports done.
// Also registers the per-pixel window result for the bitmap stage (1 clk latency).
// Legal parameter space: END_Y < START_Y, SPEED >= 1, HOLD_FRAMES >= 1.
module credits_title_scroller
   import credits_pkg::*;
#(
   parameter int OBJECT_WIDTH_X  = 64,
   parameter int OBJECT_HEIGHT_Y = 16,
   parameter int START_X         = 288,
   parameter int START_Y         = 480,
   parameter int END_Y           = 32,
   parameter int SPEED           = 2,
   parameter int HOLD_FRAMES     = 120
) (
   input logic                    clk,
   input logic                    reset,
   credits_title_scroller_if.slave bus
);

   localparam int                 HOLD_W       = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST    = HOLD_W'(HOLD_FRAMES - 1);
   localparam logic [COORD_W-1:0] Y_START      = COORD_W'(START_Y);
   localparam logic [COORD_W-1:0] Y_END        = COORD_W'(END_Y);
   localparam logic [COORD_W-1:0] Y_STEP       = COORD_W'(SPEED);
   // Clamp threshold: a step from here or below would reach or pass END_Y.
   localparam logic [CMP_W-1:0]   Y_CLAMP_AT   = CMP_W'(END_Y + SPEED);

   scroll_state_t      state;
   logic [COORD_W-1:0] top_left_y;
   logic [HOLD_W-1:0]  hold_cnt;
   logic               busy_q;
   logic               done_q;

   logic               win_in;
   logic [COORD_W-1:0] win_off_x;
   logic [COORD_W-1:0] win_off_y;
   logic               inside_q;
   logic [COORD_W-1:0] off_x_q;
   logic [COORD_W-1:0] off_y_q;

   // Scroll/hold sequencer; position moves only on frame starts so the title never tears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         top_left_y <= Y_START;
         hold_cnt   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         done_q <= 1'b0;
         if (bus.abort) begin
            // Cancel beats any start or frame event in the same cycle, and never reports done.
            state      <= IDLE;
            top_left_y <= Y_START;
            hold_cnt   <= '0;
            busy_q     <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     // First move waits for the next frame start, even if one is present now.
                     state      <= SCROLL;
                     top_left_y <= Y_START;
                     busy_q     <= 1'b1;
                  end
               end
               SCROLL: begin
                  if (bus.startOfFrame) begin
                     if (widen(top_left_y) <= Y_CLAMP_AT) begin
                        top_left_y <= Y_END;
                        hold_cnt   <= '0;
                        state      <= HOLD;
                     end else begin
                        top_left_y <= top_left_y - Y_STEP;
                     end
                  end
               end
               HOLD: begin
                  if (bus.startOfFrame) begin
                     if (hold_cnt == HOLD_LAST) begin
                        // Back to the parked-below-screen position, ready for the next start.
                        state      <= IDLE;
                        top_left_y <= Y_START;
                        hold_cnt   <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                     end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                     end
                  end
               end
               default: begin
                  state      <= IDLE;
                  top_left_y <= Y_START;
                  hold_cnt   <= '0;
                  busy_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   // Window compare against the current registered position and busy flag.
   title_rect_window #(
      .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
      .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y),
      .START_X         (START_X)
   ) u_window (
      .enable     (busy_q),
      .pixel_x    (bus.pixelX),
      .pixel_y    (bus.pixelY),
      .top_left_y (top_left_y),
      .in_window  (win_in),
      .offset_x   (win_off_x),
      .offset_y   (win_off_y)
   );

   // One-stage pixel pipeline register feeding the bitmap stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inside_q <= 1'b0;
         off_x_q  <= '0;
         off_y_q  <= '0;
      end else begin
         inside_q <= win_in;
         off_x_q  <= win_off_x;
         off_y_q  <= win_off_y;
      end
   end

   assign bus.InsideRectangle = inside_q;
   assign bus.offsetX         = off_x_q;
   assign bus.offsetY         = off_y_q;
   assign bus.topLeftY        = top_left_y;
   assign bus.busy            = busy_q;
   assign bus.done            = done_q;

endmodule
